// File: rtl/vga_frame_capture_pkg.sv
// Shared definitions for the VGA frame-capture block: default geometry, FSM states, pixel struct.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_frame_capture_pkg;

    localparam int IMG_WIDTH_DEF    = 256;
    localparam int PANEL_HEIGHT_DEF = 64;
    localparam int FIFO_DEPTH_DEF   = 16;
    localparam int FB_AW_DEF        = 14;
    localparam int RGB_W            = 24;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_CAPTURE  = 2'd2
    } cap_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

endpackage

// File: rtl/vga_frame_capture_fifo.sv
// Synchronous first-word-fall-through FIFO holding {last, addr, rgb} write entries.
// Latency: a push at edge N is visible on o_dout in the cycle after edge N.
// Backpressure: a push while full is accepted only if a pop happens in the same cycle; otherwise it is ignored.
module capture_fifo #(
    parameter int WIDTH = 39,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_pop;
    logic             w_push_ok;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_pop     = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop);
    assign o_dout    = r_mem[r_rd_ptr];

    // Storage array; contents need no reset because the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally (depth is a power of two); occupancy tracks pushes minus pops.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vga_frame_capture.sv
// Captures the IMG_WIDTH x PANEL_HEIGHT window of a VGA pixel stream into the LED frame buffer.
// Latency: pixel in cycle N -> WR_VALID/WR_ADDR/WR_DATA in cycle N+2 when the FIFO is empty.
// Backpressure: WR_READY low holds the FIFO head; pixels arriving with the FIFO full are dropped and flag OVERFLOW.
module vga_frame_capture
    import vga_frame_capture_pkg::*;
#(
    parameter int IMG_WIDTH    = IMG_WIDTH_DEF,
    parameter int PANEL_HEIGHT = PANEL_HEIGHT_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int FB_AW        = FB_AW_DEF
) (
    input  logic             i_pclk,
    input  logic             i_reset_n,
    input  logic [10:0]      i_addr_h,
    input  logic [9:0]       i_addr_v,
    input  logic [7:0]       i_vga_r,
    input  logic [7:0]       i_vga_g,
    input  logic [7:0]       i_vga_b,
    input  logic             i_cap_en,
    input  logic             i_cap_cont,
    input  logic             i_ovf_clr,
    output logic             o_wr_valid,
    input  logic             i_wr_ready,
    output logic [FB_AW-1:0] o_wr_addr,
    output logic [23:0]      o_wr_data,
    output logic             o_cap_busy,
    output logic             o_frame_done,
    output logic             o_overflow
);
    localparam int HW = $clog2(IMG_WIDTH);
    localparam int VW = $clog2(PANEL_HEIGHT);
    localparam int EW = FB_AW + RGB_W + 1;
    localparam logic [10:0] LIM_H = 11'(IMG_WIDTH);
    localparam logic [9:0]  LIM_V = 10'(PANEL_HEIGHT);

    cap_state_t       r_state;
    logic             r_stg_vld;
    logic             r_stg_last;
    logic [FB_AW-1:0] r_stg_addr;
    rgb888_t          r_stg_rgb;
    logic             r_frame_done;
    logic             r_overflow;

    logic             w_in_win;
    logic             w_sof;
    logic             w_last;
    logic             w_cap_px;
    logic [HW-1:0]    w_col;
    logic [VW-1:0]    w_row;
    logic [FB_AW-1:0] w_addr;
    logic [EW-1:0]    w_din;
    logic [EW-1:0]    w_dout;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_drop;

    assign w_in_win = (i_addr_h != 11'd0) && (i_addr_h <= LIM_H) &&
                      (i_addr_v != 10'd0) && (i_addr_v <= LIM_V);
    assign w_sof    = (i_addr_h == 11'd1) && (i_addr_v == 10'd1);
    assign w_last   = (i_addr_h == LIM_H) && (i_addr_v == LIM_V);

    // Window sizes are powers of two, so the row-major address is a plain concatenation.
    assign w_col  = i_addr_h[HW-1:0] - 1'b1;
    assign w_row  = i_addr_v[VW-1:0] - 1'b1;
    assign w_addr = {w_row, w_col};

    // Decide whether the current pixel is taken: the SOF pixel opens a frame, then every in-window pixel.
    always_comb begin
        w_cap_px = 1'b0;
        case (r_state)
            ST_WAIT_SOF: w_cap_px = i_cap_en & w_sof;
            ST_CAPTURE:  w_cap_px = i_cap_en & w_in_win;
            default:     w_cap_px = 1'b0;
        endcase
    end

    // Capture sequencing; dropping CAP_EN aborts immediately so the last marker never gets queued.
    always_ff @(posedge i_pclk) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_cap_en) r_state <= ST_WAIT_SOF;
                end
                ST_WAIT_SOF: begin
                    if (!i_cap_en)  r_state <= ST_IDLE;
                    else if (w_sof) r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (!i_cap_en)
                        r_state <= ST_IDLE;
                    else if (w_in_win && w_last)
                        r_state <= i_cap_cont ? ST_WAIT_SOF : ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Stage register decouples the window decode from the FIFO write.
    always_ff @(posedge i_pclk) begin
        if (!i_reset_n) begin
            r_stg_vld  <= 1'b0;
            r_stg_last <= 1'b0;
            r_stg_addr <= '0;
            r_stg_rgb  <= '0;
        end else begin
            r_stg_vld  <= w_cap_px;
            r_stg_last <= w_last;
            r_stg_addr <= w_addr;
            r_stg_rgb  <= '{r: i_vga_r, g: i_vga_g, b: i_vga_b};
        end
    end

    assign w_din  = {r_stg_last, r_stg_addr, r_stg_rgb};
    assign w_pop  = o_wr_valid & i_wr_ready;
    assign w_drop = r_stg_vld & w_full & ~w_pop;

    capture_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_pclk),
        .i_rst_n (i_reset_n),
        .i_push  (r_stg_vld),
        .i_pop   (w_pop),
        .i_din   (w_din),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Frame-done pulse after the last-marked entry leaves; overflow is sticky, set beats clear.
    always_ff @(posedge i_pclk) begin
        if (!i_reset_n) begin
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= w_pop & w_dout[EW-1];
            if (w_drop)
                r_overflow <= 1'b1;
            else if (i_ovf_clr)
                r_overflow <= 1'b0;
        end
    end

    // Stale RAM contents are masked so the write port reads all-zero while idle.
    assign o_wr_valid   = ~w_empty;
    assign o_wr_addr    = w_empty ? '0 : w_dout[EW-2:RGB_W];
    assign o_wr_data    = w_empty ? '0 : w_dout[RGB_W-1:0];
    assign o_cap_busy   = (r_state != ST_IDLE) | r_stg_vld | ~w_empty;
    assign o_frame_done = r_frame_done;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Self-checking bench for vga_frame_capture with a transaction-level reference model.
// Latency: n/a.
// Backpressure: the bench drives WR_READY directly.
module tb_vga_frame_capture;

    localparam int W    = 256;
    localparam int H    = 64;
    localparam int D    = 16;
    localparam int LINE = W + 1;        // one blanking column per line
    localparam int FRM  = LINE * (H + 1); // one blanking line per frame

    logic        clk = 1'b0;
    logic        rst_n, cap_en, cap_cont, ovf_clr, wr_ready;
    logic [10:0] addr_h;
    logic [9:0]  addr_v;
    logic [7:0]  vr, vg, vb;
    logic        wr_valid, cap_busy, frame_done, overflow;
    logic [13:0] wr_addr;
    logic [23:0] wr_data;
    logic [41:0] dut_vec;

    always #5 clk = ~clk;

    vga_frame_capture dut (
        .i_pclk       (clk),
        .i_reset_n    (rst_n),
        .i_addr_h     (addr_h),
        .i_addr_v     (addr_v),
        .i_vga_r      (vr),
        .i_vga_g      (vg),
        .i_vga_b      (vb),
        .i_cap_en     (cap_en),
        .i_cap_cont   (cap_cont),
        .i_ovf_clr    (ovf_clr),
        .o_wr_valid   (wr_valid),
        .i_wr_ready   (wr_ready),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_cap_busy   (cap_busy),
        .o_frame_done (frame_done),
        .o_overflow   (overflow)
    );

    assign dut_vec = {wr_valid, wr_addr, wr_data, frame_done, overflow, cap_busy};

    int checks = 0;
    int errors = 0;

    // Reference model: a bounded queue of pending frame-buffer writes plus one staged pixel.
    typedef struct {
        int          addr;
        logic [23:0] data;
        bit          last;
    } ent_t;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_CAP  = 2;

    ent_t        mq[$];
    ent_t        mstg;
    bit          mstg_vld;
    int          mstate;
    bit          movf;
    bit          mdone;
    logic [41:0] m_exp;

    bit          xfer;
    int          xfer_addr;
    logic [23:0] xfer_data;

    function automatic logic [23:0] grad(input int h, input int v);
        logic [7:0] a, b, c;
        a = h[7:0];
        b = v[7:0];
        c = 8'(h + v);
        return {a, b, c};
    endfunction

    function automatic int pos_h(input int p);
        return p % LINE + 1;
    endfunction

    function automatic int pos_v(input int p);
        return p / LINE + 1;
    endfunction

    // One pixel clock: drive inputs, note any transfer, advance the model, cross the edge.
    task automatic step(input int h, input int v, input logic [23:0] rgb);
        bit   inwin, sof, last, cap, pop;
        ent_t e;
        logic [13:0] a14;
        addr_h = 11'(h);
        addr_v = 10'(v);
        {vr, vg, vb} = rgb;
        #1;
        xfer = (wr_valid === 1'b1) && (wr_ready === 1'b1);
        if (xfer) begin
            xfer_addr = int'(wr_addr);
            xfer_data = wr_data;
        end
        if (!rst_n) begin
            mq.delete();
            mstg_vld = 1'b0;
            mstate   = M_IDLE;
            movf     = 1'b0;
            mdone    = 1'b0;
        end else begin
            pop   = (mq.size() > 0) && wr_ready;
            mdone = pop && mq[0].last;
            if (pop) e = mq.pop_front();
            if (mstg_vld && mq.size() < D) begin
                mq.push_back(mstg);
                if (ovf_clr) movf = 1'b0;
            end else if (mstg_vld) begin
                movf = 1'b1;
            end else if (ovf_clr) begin
                movf = 1'b0;
            end
            inwin = (h >= 1) && (h <= W) && (v >= 1) && (v <= H);
            sof   = (h == 1) && (v == 1);
            last  = (h == W) && (v == H);
            cap   = 1'b0;
            if (mstate == M_IDLE) begin
                if (cap_en) mstate = M_WAIT;
            end else if (!cap_en) begin
                mstate = M_IDLE;
            end else if (mstate == M_WAIT) begin
                if (sof) begin
                    cap    = 1'b1;
                    mstate = M_CAP;
                end
            end else if (inwin) begin
                cap = 1'b1;
                if (last) mstate = cap_cont ? M_WAIT : M_IDLE;
            end
            mstg_vld  = cap;
            mstg.addr = (v - 1) * W + (h - 1);
            mstg.data = rgb;
            mstg.last = last;
        end
        e.addr = 0;
        e.data = '0;
        e.last = 1'b0;
        if (mq.size() > 0) e = mq[0];
        a14 = e.addr[13:0];
        m_exp = {mq.size() > 0, a14, e.data, mdone, movf,
                 (mstate != M_IDLE) || mstg_vld || (mq.size() > 0)};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cap_en = 1'b0; cap_cont = 1'b0; ovf_clr = 1'b0; wr_ready = 1'b1;
        step(0, 0, 24'd0);
        step(0, 0, 24'd0);
        checks++;
        if (dut_vec !== 42'd0) begin
            errors++; $display("FAIL reset_outputs got=%h want=0", dut_vec);
        end
        rst_n = 1'b1;
        step(0, 0, 24'd0);
        checks++;
        if (dut_vec !== m_exp) begin
            errors++; $display("FAIL reset_release got=%h want=%h", dut_vec, m_exp);
        end
    endtask

    task automatic test_single_frame();
        int n = 0;
        int dn = 0;
        cap_en = 1'b1; cap_cont = 1'b0; wr_ready = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 24'd0);
        for (int p = 0; p < H * LINE; p++) begin
            step(pos_h(p), pos_v(p), grad(pos_h(p), pos_v(p)));
            checks++;
            if (dut_vec !== m_exp) begin
                errors++; $display("FAIL frame1_vec p=%0d got=%h want=%h", p, dut_vec, m_exp);
            end
            if (p == 0) begin
                checks++;
                if (wr_valid !== 1'b0) begin
                    errors++; $display("FAIL latency_n1 got=%b want=0", wr_valid);
                end
            end
            if (p == 1) begin
                checks++;
                if (wr_valid !== 1'b1 || wr_addr !== 14'd0) begin
                    errors++; $display("FAIL latency_n2 got v=%b a=%0d want v=1 a=0", wr_valid, wr_addr);
                end
            end
            if (xfer) begin
                checks++;
                if (xfer_addr != n || xfer_data !== grad(n % W + 1, n / W + 1)) begin
                    errors++; $display("FAIL frame1_order got a=%0d d=%h want a=%0d d=%h",
                                       xfer_addr, xfer_data, n, grad(n % W + 1, n / W + 1));
                end
                n++;
            end
            if (frame_done === 1'b1) dn++;
        end
        cap_en = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step(0, 0, 24'd0);
            checks++;
            if (dut_vec !== m_exp) begin
                errors++; $display("FAIL frame1_drain got=%h want=%h", dut_vec, m_exp);
            end
            if (xfer) n++;
            if (frame_done === 1'b1) dn++;
        end
        checks++;
        if (n != W * H) begin errors++; $display("FAIL frame1_count got=%0d want=%0d", n, W * H); end
        checks++;
        if (dn != 1) begin errors++; $display("FAIL frame1_done got=%0d want=1", dn); end
        checks++;
        if (cap_busy !== 1'b0) begin errors++; $display("FAIL frame1_busy got=%b want=0", cap_busy); end
    endtask

    task automatic test_overflow_abort();
        int nx = 0;
        int dn = 0;
        int got17 = -1;
        cap_en = 1'b1; cap_cont = 1'b0; wr_ready = 1'b1;
        step(0, 0, 24'd0);
        step(0, 0, 24'd0);
        for (int p = 0; p <= 9 * LINE; p++) begin
            wr_ready = !(p >= 1 && p <= 20);
            cap_en   = (pos_v(p) < 10);
            ovf_clr  = (p == 40);
            step(pos_h(p), pos_v(p), 24'($urandom));
            checks++;
            if (dut_vec !== m_exp) begin
                errors++; $display("FAIL ovf_vec p=%0d got=%h want=%h", p, dut_vec, m_exp);
            end
            if (xfer) begin
                if (nx == 16) got17 = xfer_addr;
                nx++;
            end
            if (frame_done === 1'b1) dn++;
            if (p == 20) begin
                checks++;
                if (overflow !== 1'b1 || wr_valid !== 1'b1) begin
                    errors++; $display("FAIL ovf_set got o=%b v=%b want o=1 v=1", overflow, wr_valid);
                end
            end
            if (p == 40) begin
                checks++;
                if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b want=0", overflow); end
            end
        end
        ovf_clr = 1'b0;
        wr_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step(0, 0, 24'd0);
            checks++;
            if (dut_vec !== m_exp) begin
                errors++; $display("FAIL abort_drain got=%h want=%h", dut_vec, m_exp);
            end
            if (xfer) nx++;
            if (frame_done === 1'b1) dn++;
        end
        checks++;
        if (got17 != 20) begin errors++; $display("FAIL ovf_gap got=%0d want=20", got17); end
        checks++;
        if (nx != 9 * W - 4) begin errors++; $display("FAIL abort_count got=%0d want=%0d", nx, 9 * W - 4); end
        checks++;
        if (dn != 0) begin errors++; $display("FAIL abort_done got=%0d want=0", dn); end
        checks++;
        if (cap_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", cap_busy); end
    endtask

    task automatic test_arm_midframe_cont();
        int nx = 0;
        cap_cont = 1'b1; wr_ready = 1'b1; cap_en = 1'b1;
        for (int p = 29 * LINE; p < FRM; p++) begin
            step(pos_h(p), pos_v(p), 24'($urandom));
            checks++;
            if (dut_vec !== m_exp) begin
                errors++; $display("FAIL arm_vec p=%0d got=%h want=%h", p, dut_vec, m_exp);
            end
            if (xfer) nx++;
        end
        checks++;
        if (nx != 0) begin errors++; $display("FAIL arm_early_writes got=%0d want=0", nx); end
        for (int f = 0; f < 2; f++) begin
            int dn = 0;
            nx = 0;
            for (int p = 0; p < FRM; p++) begin
                step(pos_h(p), pos_v(p), 24'($urandom));
                checks++;
                if (dut_vec !== m_exp) begin
                    errors++; $display("FAIL cont_vec f=%0d p=%0d got=%h want=%h", f, p, dut_vec, m_exp);
                end
                if (xfer) nx++;
                if (frame_done === 1'b1) dn++;
            end
            checks++;
            if (dn != 1) begin errors++; $display("FAIL cont_done f=%0d got=%0d want=1", f, dn); end
            checks++;
            if (nx != W * H) begin errors++; $display("FAIL cont_count f=%0d got=%0d want=%0d", f, nx, W * H); end
        end
        cap_en = 1'b0;
        for (int i = 0; i < 4; i++) step(0, 0, 24'd0);
        checks++;
        if (cap_busy !== 1'b0) begin errors++; $display("FAIL cont_busy got=%b want=0", cap_busy); end
    endtask

    task automatic test_reset_midframe();
        cap_en = 1'b1; cap_cont = 1'b0; wr_ready = 1'b1;
        step(0, 0, 24'd0);
        step(0, 0, 24'd0);
        for (int p = 0; p <= 8; p++) begin
            wr_ready = (p == 0);
            step(pos_h(p), pos_v(p), 24'($urandom));
            checks++;
            if (dut_vec !== m_exp) begin
                errors++; $display("FAIL fill_vec p=%0d got=%h want=%h", p, dut_vec, m_exp);
            end
        end
        rst_n = 1'b0;
        step(pos_h(9), pos_v(9), 24'($urandom));
        checks++;
        if (dut_vec !== 42'd0) begin errors++; $display("FAIL midreset_outputs got=%h want=0", dut_vec); end
        rst_n = 1'b1; cap_en = 1'b0; wr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 24'd0);
            checks++;
            if (wr_valid !== 1'b0 || frame_done !== 1'b0 || cap_busy !== 1'b0) begin
                errors++; $display("FAIL midreset_after got v=%b d=%b b=%b want 0", wr_valid, frame_done, cap_busy);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; cap_en = 1'b0; cap_cont = 1'b0; ovf_clr = 1'b0; wr_ready = 1'b1;
        addr_h = '0; addr_v = '0; vr = '0; vg = '0; vb = '0;
        test_reset();
        test_single_frame();
        test_overflow_abort();
        test_arm_midframe_cont();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
